act_pipe: RTL
=============

Name: act_pipe

Overview:
- Parametrised, multi-lane, pipelined activation unit; successor to the single-lane fixed ReLU.
- Sits between a compute stage (conv/matmul accumulator output) and the next layer's input stream.
- Processes LANES signed two's-complement elements per beat.
- Selectable function: identity, ReLU, leaky ReLU or clipped ReLU.
- Uses a valid/ready handshake in place of the bare `running` hold.

Parameters:
DATA_W, 32, element width in bits (signed two's complement), >= 8
LANES, 4, elements per beat, >= 1
SHIFT_W, 5, width of leak_shift, must equal clog2(DATA_W)

Ports:
clk  input  1  clock, all state on rising edge
rst  input  1  asynchronous active-high reset
running  input  1  global enable; 0 freezes the pipeline
mode  input  2  0=identity, 1=ReLU, 2=leaky ReLU, 3=clipped ReLU; sampled per beat at input acceptance
leak_shift  input  SHIFT_W  arithmetic right shift applied to negatives in mode 2; sampled with mode
clip_max  input  DATA_W  signed upper bound for mode 3; sampled with mode
in_valid  input  1  input beat valid
in_ready  output  1  unit can accept a beat
in0  input  LANES*DATA_W  lane i at bits [i*DATA_W +: DATA_W]
out_valid  output  1  output beat valid
out_ready  input  1  consumer accepts the beat
out0  output  LANES*DATA_W  activated lanes, same packing as in0

Behaviour:
- Reset (asynchronous, any time including mid-stream): all pipeline valid bits, data and sampled config registers clear to 0. Consequently out_valid=0 and out0=0. in_ready follows the combinational rule below.
- Pipeline advance enable: en = running && (!s2_valid || out_ready).
- in_ready = en (combinational, no dependence on in_valid).
- out_valid = s2_valid && running.
- Stage 1, when en: s1_valid<=in_valid. If in_valid, also register in0, mode, leak_shift, clip_max.
- Stage 2, when en: s2_valid<=s1_valid. Register the activation of the stage-1 data into out0.
- Latency: accepted beat appears on out0/out_valid exactly 2 cycles after the accepting edge when unstalled. Throughput is 1 beat/cycle.
- Bubbles are not collapsed: an empty s1 still shifts only when en.
- When en=0, all stage registers hold. out0 stays stable whenever s2_valid=1 and no transfer occurs.
- running=0: in_ready=0 and out_valid=0, no handshake either side, contents preserved. Re-asserting running resumes with identical data.
- Transfers: input on in_valid&&in_ready; output on out_valid&&out_ready. Simultaneous input and output transfer in the same cycle is legal and loses nothing.
- Per-lane function, x signed:
  - mode 0: y=x.
  - mode 1: y = x<0 ? 0 : x.
  - mode 2: y = x<0 ? (x >>> leak_shift) : x. Floor rounding. Shift 0 gives y=x. Shift DATA_W-1 gives -1 for any negative x.
  - mode 3: y = x<0 ? 0 : min(x, clip_max), signed compare. If clip_max<0, y=0 for every lane.
- No width growth; results always fit in DATA_W.

Optional Feature:
- Macro ACT_PIPE_STATS_EN.
- Defined: adds input stats_clr (1) and output zero_count (32). The counter increments by the number of lanes whose stage-2 result is 0 while the input was nonzero, counted only on output transfer. It saturates at 32'hFFFF_FFFF. stats_clr synchronously clears it, taking priority over that cycle's increment. rst clears it asynchronously.
- Undefined: no extra ports, no counter logic.

Decomposition:
- Package act_pipe_pkg holds:
  - mode enum: ACT_IDENTITY=0, ACT_RELU=1, ACT_LEAKY=2, ACT_CLIP=3;
  - default width constants;
  - a pure function computing one lane's activation.
- Sub-module act_lane: one lane's stage-2 register with the package function, instantiated LANES times via generate.
- Valid/enable control lives once in act_pipe.

Test Plan:
- Reset then release, mode=1, LANES=4, stream {0, 32'h8000_0001, 5, 32'h7FFF_FFFF} per lane → each beat 2 cycles later shows {0, 0, 5, 32'h7FFF_FFFF}; out0=0 and out_valid=0 right after reset.
- Mode 2, leak_shift=3, in lane values {-16, -1, -9, 40} → {-2, -1, -2, 40}. Then leak_shift=31 with -5 → -1.
- Mode 3, clip_max=6: {-3, 4, 6, 100} → {0, 4, 6, 6}. Then clip_max=-1 with {7, 0, -2, 1} → all 0.
- Back-to-back 8 beats with out_ready toggling 1,0,0,1 and mode changing every beat → every beat delivered once, in order, each computed with the mode sampled at its acceptance; out0 stable while stalled.
- running dropped for 3 cycles with 2 beats in flight → in_ready=0 and out_valid=0 during the gap, then both beats emerge unchanged. rst pulsed mid-stream → out_valid=0 and out0=0 immediately (asynchronous), no stale beat afterwards.
- With ACT_PIPE_STATS_EN, mode 1, 3 beats of {-1, 2, -7, 0} transferred → zero_count=6. stats_clr coincident with a transfer → zero_count=0.

Source files
------------

// File: rtl/act_pipe_pkg.sv
// act_pipe_pkg: shared mode encoding, default widths and the per-lane activation function.
// Latency: n/a (combinational helper only).
// Backpressure: n/a.
// The function works at a fixed 64-bit width; callers sign-extend in and truncate out,
// which is exact for any DATA_W <= 64 since results never grow past the input width.
package act_pipe_pkg;

  localparam int ACT_DATA_W      = 32;
  localparam int ACT_LANES       = 4;
  localparam int ACT_SHIFT_W     = 5;
  localparam int ACT_MAX_W       = 64;
  localparam int ACT_MAX_SHIFT_W = 6;

  typedef enum logic [1:0] {
    ACT_IDENTITY = 2'd0,
    ACT_RELU     = 2'd1,
    ACT_LEAKY    = 2'd2,
    ACT_CLIP     = 2'd3
  } act_mode_e;

  function automatic logic signed [ACT_MAX_W-1:0] act_fn(
    input logic signed [ACT_MAX_W-1:0]       x,
    input act_mode_e                         m,
    input logic        [ACT_MAX_SHIFT_W-1:0] sh,
    input logic signed [ACT_MAX_W-1:0]       clip
  );
    logic signed [ACT_MAX_W-1:0] y;
    y = x;
    case (m)
      ACT_IDENTITY: y = x;
      ACT_RELU:     y = x[ACT_MAX_W-1] ? '0 : x;
      // Arithmetic shift floors toward -inf, so any negative saturates at -1.
      ACT_LEAKY:    y = x[ACT_MAX_W-1] ? (x >>> sh) : x;
      // A negative ceiling would otherwise leak a negative value through min().
      ACT_CLIP: begin
        if (x[ACT_MAX_W-1] || clip[ACT_MAX_W-1]) y = '0;
        else if (x > clip)                       y = clip;
        else                                     y = x;
      end
      default:      y = x;
    endcase
    return y;
  endfunction

endpackage

// File: rtl/act_pipe_if.sv
// act_pipe_if: input/output beat streams of act_pipe with valid/ready handshakes.
// Latency: n/a (wiring only).
// Backpressure: out_ready from the consumer, in_ready back to the producer.
// Ports: in_valid/in_ready/in0 (input beat), out_valid/out_ready/out0 (output beat);
// lane i occupies bits [i*DATA_W +: DATA_W] on both buses.
interface act_pipe_if #(
  parameter int DATA_W = 32,
  parameter int LANES  = 4
);
  logic                    in_valid;
  logic                    in_ready;
  logic [LANES*DATA_W-1:0] in0;
  logic                    out_valid;
  logic                    out_ready;
  logic [LANES*DATA_W-1:0] out0;

  // slave: the activation unit; master: the surrounding producer/consumer.
  modport slave  (input in_valid, in0, out_ready, output in_ready, out_valid, out0);
  modport master (output in_valid, in0, out_ready, input in_ready, out_valid, out0);
endinterface

// File: rtl/act_lane.sv
// act_lane: stage-2 register of one lane, loaded with the activation of the stage-1 element.
// Latency: 1 cycle (registered on en).
// Backpressure: holds its value whenever en=0.
// Ports: clk, rst, en, x/mode/shift/clip (stage-1 element and config), y (result);
// with ACT_PIPE_STATS_EN also killed = nonzero input activated to zero.
module act_lane
  import act_pipe_pkg::*;
#(
  parameter int DATA_W  = ACT_DATA_W,
  parameter int SHIFT_W = ACT_SHIFT_W
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               en,
  input  logic [DATA_W-1:0]  x,
  input  act_mode_e          mode,
  input  logic [SHIFT_W-1:0] shift,
  input  logic [DATA_W-1:0]  clip,
  output logic [DATA_W-1:0]  y
`ifdef ACT_PIPE_STATS_EN
  ,
  output logic               killed
`endif
);

  logic signed [ACT_MAX_W-1:0] x_ext;
  logic signed [ACT_MAX_W-1:0] clip_ext;
  logic        [DATA_W-1:0]    y_nxt;

  assign x_ext    = ACT_MAX_W'($signed(x));
  assign clip_ext = ACT_MAX_W'($signed(clip));
  assign y_nxt    = DATA_W'(act_fn(x_ext, mode, ACT_MAX_SHIFT_W'(shift), clip_ext));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      y <= '0;
    end else if (en) begin
      y <= y_nxt;
    end
  end

`ifdef ACT_PIPE_STATS_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      killed <= 1'b0;
    end else if (en) begin
      killed <= (x != '0) && (y_nxt == '0);
    end
  end
`endif

endmodule

// File: rtl/act_pipe.sv
// act_pipe: LANES-wide two-stage activation pipeline (identity/ReLU/leaky/clipped ReLU).
// Latency: 2 cycles from accepting edge to out0 update; 1 beat/cycle throughput.
// Backpressure: whole pipe advances only when running and s2 is empty or being consumed.
// Ports: clk, rst (async active-high), running, mode, leak_shift, clip_max (sampled with
// each accepted beat), bus (act_pipe_if slave). Optional macro ACT_PIPE_STATS_EN adds
// stats_clr and a saturating zero_count of lanes zeroed from nonzero inputs.
module act_pipe
  import act_pipe_pkg::*;
#(
  parameter int DATA_W  = ACT_DATA_W,
  parameter int LANES   = ACT_LANES,
  parameter int SHIFT_W = ACT_SHIFT_W
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               running,
  input  logic [1:0]         mode,
  input  logic [SHIFT_W-1:0] leak_shift,
  input  logic [DATA_W-1:0]  clip_max,
  act_pipe_if.slave          bus
`ifdef ACT_PIPE_STATS_EN
  ,
  input  logic               stats_clr,
  output logic [31:0]        zero_count
`endif
);

  logic                    en;
  logic                    s1_valid;
  logic                    s2_valid;
  logic [LANES*DATA_W-1:0] s1_data;
  act_mode_e               s1_mode;
  logic [SHIFT_W-1:0]      s1_shift;
  logic [DATA_W-1:0]       s1_clip;
  logic [LANES*DATA_W-1:0] out_dat;

  // Bubbles travel with the pipe rather than being collapsed.
  assign en            = running && (!s2_valid || bus.out_ready);
  assign bus.in_ready  = en;
  assign bus.out_valid = s2_valid && running;
  assign bus.out0      = out_dat;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_valid <= 1'b0;
      s2_valid <= 1'b0;
      s1_data  <= '0;
      s1_mode  <= ACT_IDENTITY;
      s1_shift <= '0;
      s1_clip  <= '0;
    end else if (en) begin
      s1_valid <= bus.in_valid;
      s2_valid <= s1_valid;
      if (bus.in_valid) begin
        s1_data  <= bus.in0;
        s1_mode  <= act_mode_e'(mode);
        s1_shift <= leak_shift;
        s1_clip  <= clip_max;
      end
    end
  end

`ifdef ACT_PIPE_STATS_EN
  logic [LANES-1:0] killed;
`endif

  for (genvar i = 0; i < LANES; i++) begin : g_lane
    act_lane #(
      .DATA_W  (DATA_W),
      .SHIFT_W (SHIFT_W)
    ) u_lane (
      .clk   (clk),
      .rst   (rst),
      .en    (en),
      .x     (s1_data[i*DATA_W +: DATA_W]),
      .mode  (s1_mode),
      .shift (s1_shift),
      .clip  (s1_clip),
      .y     (out_dat[i*DATA_W +: DATA_W])
`ifdef ACT_PIPE_STATS_EN
      ,
      .killed (killed[i])
`endif
    );
  end

`ifdef ACT_PIPE_STATS_EN
  logic [31:0] inc;
  logic [32:0] sum;

  always_comb begin
    inc = '0;
    for (int i = 0; i < LANES; i++) begin
      inc = inc + 32'(killed[i]);
    end
  end

  assign sum = {1'b0, zero_count} + {1'b0, inc};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      zero_count <= '0;
    end else if (stats_clr) begin
      zero_count <= '0;
    end else if (bus.out_valid && bus.out_ready) begin
      zero_count <= sum[32] ? 32'hFFFF_FFFF : sum[31:0];
    end
  end
`endif

endmodule
